// File: rtl/rtg_pkg.sv
// Shared types and constants for the random test-pattern generator.
//   rtg_state_t : controller states (IDLE, RUN, DONE)
//   TAP_HI/LO   : feedback taps of x^33 + x^20 + 1 (Fibonacci form)
//   SEED        : reset seed and replacement for an all-zero seed load
package rtg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rtg_state_t;

  localparam int TAP_HI = 32;
  localparam int TAP_LO = 19;

  localparam logic [32:0] SEED = 33'h1;

endpackage

// File: rtl/rtg_lfsr.sv
// Fibonacci LFSR holding the current test vector.
// Ports:
//   clk, rst  : clock and async active-high reset (state returns to SEED)
//   load      : load loadVal (an all-zero value is replaced by SEED)
//   loadVal   : candidate seed
//   advance   : shift one step; ignored while load is high
//   state     : current LFSR contents, bit 0 is the newest feedback bit
module rtg_lfsr import rtg_pkg::*; #(
  parameter int               WIDTH = 33,
  parameter logic [WIDTH-1:0] SEED  = rtg_pkg::SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  logic             feedback;
  logic [WIDTH-1:0] seedVal;

  assign feedback = state[TAP_HI] ^ state[TAP_LO];

  // Zero is the lock-up state of an XOR LFSR, so it is never allowed in.
  assign seedVal = (loadVal == '0) ? SEED : loadVal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= seedVal;
    end else if (advance) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/rtg_pattern_gen.sv
// Random test-pattern generator: issues LFSR vectors over valid/ready until
// the latched vector budget is used up.
// Ports:
//   clk, rst            : clock and async active-high reset
//   start, abort        : begin a run (IDLE/DONE), end a run early (RUN)
//   seed_load, seed     : reseed the LFSR while not running
//   max_count           : vectors per run, latched with start
//   vec_valid/vec_ready : handshake; vec is the LFSR state, vec_index its
//                         zero-based position in the run
//   busy, done          : high in RUN / high in DONE
//
// state | meaning
// IDLE  | no run active; accepts start and seed_load
// RUN   | presenting vectors; a transfer advances LFSR and index
// DONE  | budget exhausted; done held until the next start
module rtg_pattern_gen import rtg_pkg::*; #(
  parameter int               WIDTH = 33,
  parameter logic [WIDTH-1:0] SEED  = rtg_pkg::SEED,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] max_count,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] vec_index,
  output logic             busy,
  output logic             done
);

  rtg_state_t       state;
  logic [CNT_W-1:0] maxCnt;
  logic             running;
  logic             lfsrLoad;
  logic             lfsrAdvance;
  logic             lastVec;

  assign running     = (state == RUN);
  assign lfsrLoad    = !running && seed_load;
  // Abort wins over a simultaneous transfer: the vector on the bus stays put.
  assign lfsrAdvance = running && vec_ready && !abort;
  assign lastVec     = (vec_index == maxCnt - 1'b1);

  rtg_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) uLfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsrLoad),
    .loadVal (seed),
    .advance (lfsrAdvance),
    .state   (vec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      maxCnt    <= '0;
      vec_index <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            maxCnt    <= max_count;
            vec_index <= '0;
            if (max_count == '0) begin
              state     <= DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= RUN;
              vec_valid <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (vec_ready) begin
            vec_index <= vec_index + 1'b1;
            if (lastVec) begin
              state     <= DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtg_pattern_gen.sv
module tb_rtg_pattern_gen;

  localparam int WIDTH = 33;
  localparam int CNT_W = 16;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             seed_load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [CNT_W-1:0] max_count = '0;
  logic             vec_ready = 1'b0;
  logic             vec_valid;
  logic [WIDTH-1:0] vec;
  logic [CNT_W-1:0] vec_index;
  logic             busy;
  logic             done;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  rtg_pattern_gen #(
    .WIDTH (WIDTH),
    .SEED  (33'h1),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .seed_load (seed_load),
    .seed      (seed),
    .max_count (max_count),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec       (vec),
    .vec_index (vec_index),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  int              mPhase  = P_IDLE;
  logic [32:0]     mVec    = 33'h1;
  logic [15:0]     mIdx    = '0;
  int              mRemain = 0;
  logic [32:0]     xferLog[$];

  // One step of the sequence generated by x^33 + x^20 + 1.
  function automatic logic [32:0] nextVec(input logic [32:0] v);
    logic [32:0] r;
    r = v << 1;
    r[0] = v[32] ^ v[19];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase  = P_IDLE;
      mVec    = 33'h1;
      mIdx    = '0;
      mRemain = 0;
    end else if (mPhase != P_RUN) begin
      if (seed_load) mVec = (seed == '0) ? 33'h1 : seed;
      if (start) begin
        mIdx = '0;
        if (max_count == '0) mPhase = P_DONE;
        else begin
          mPhase  = P_RUN;
          mRemain = int'(max_count);
        end
      end
    end else if (abort) begin
      mPhase = P_IDLE;
    end else if (vec_ready) begin
      xferLog.push_back(vec);
      mVec    = nextVec(mVec);
      mIdx    = mIdx + 16'd1;
      mRemain = mRemain - 1;
      if (mRemain == 0) mPhase = P_DONE;
    end
  end

  always @(negedge clk) begin
    check("vec_valid", 64'(vec_valid), 64'(mPhase == P_RUN));
    check("busy",      64'(busy),      64'(mPhase == P_RUN));
    check("done",      64'(done),      64'(mPhase == P_DONE));
    check("vec_index", 64'(vec_index), 64'(mIdx));
    check("vec",       64'(vec),       64'(mVec));
  end

  // ---------------- helpers ----------------
  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 64'(done), 64'd1);
  endtask

  task automatic waitIdx(input int target, input int budget);
    int n = 0;
    while (int'(vec_index) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_index", 64'(vec_index), 64'(target));
  endtask

  // Run of 21 from seed 1: single bit walking up, then the first tap feedback.
  task automatic checkLog(input string tag);
    logic [32:0] e;
    check({tag, "_count"}, 64'(xferLog.size()), 64'd21);
    for (int i = 0; i < xferLog.size() && i < 21; i++) begin
      e = 33'h1 << i;
      if (i == 20) e = 33'h000100001;
      check(tag, 64'(xferLog[i]), 64'(e));
    end
  endtask

  task automatic startRun(input logic [32:0] s, input logic [15:0] cnt, input logic rdy);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    start     = 1'b1;
    max_count = cnt;
    vec_ready = rdy;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        validSeen;
    logic [63:0] r;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_vec",   64'(vec),       64'h1);
    check("reset_index", 64'(vec_index), 64'd0);
    check("reset_valid", 64'(vec_valid), 64'd0);
    check("reset_busy",  64'(busy),      64'd0);
    check("reset_done",  64'(done),      64'd0);
    rst = 1'b0;

    // Back-to-back run of 21 vectors.
    xferLog.delete();
    startRun(33'h1, 16'd21, 1'b1);
    check("first_vec", 64'(vec), 64'h1);
    waitDone(100);
    check("final_index", 64'(vec_index), 64'd21);
    checkLog("run_nostall");

    // Same run with ready toggling 1-0-0-1.
    xferLog.delete();
    startRun(33'h1, 16'd21, 1'b1);
    for (int c = 1; c < 300 && !done; c++) begin
      vec_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
    end
    check("stall_done", 64'(done), 64'd1);
    checkLog("run_stall");
    vec_ready = 1'b1;

    // All-zero seed is replaced by SEED.
    startRun(33'h0, 16'd3, 1'b0);
    check("zero_seed_vec", 64'(vec), 64'h1);
    check("zero_seed_valid", 64'(vec_valid), 64'd1);
    vec_ready = 1'b1;
    waitDone(20);

    // Abort together with a transfer at index 5.
    startRun(33'h1, 16'd20, 1'b1);
    waitIdx(5, 50);
    abort = 1'b1;
    vec_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  64'(busy),      64'd0);
    check("abort_valid", 64'(vec_valid), 64'd0);
    check("abort_vec",   64'(vec),       64'h20);
    check("abort_index", 64'(vec_index), 64'd5);

    // Zero budget: straight to DONE, never valid.
    @(negedge clk);
    start = 1'b1;
    max_count = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_count_done", 64'(done), 64'd1);
    validSeen = vec_valid;
    repeat (5) begin
      @(negedge clk);
      validSeen = validSeen | vec_valid;
    end
    check("zero_count_never_valid", 64'(validSeen), 64'd0);

    // Asynchronous reset in the middle of a run.
    startRun(33'h0_1234_5678, 16'd30, 1'b1);
    waitIdx(7, 50);
    #2 rst = 1'b1;
    #1;
    check("async_rst_vec",   64'(vec),       64'h1);
    check("async_rst_index", 64'(vec_index), 64'd0);
    check("async_rst_valid", 64'(vec_valid), 64'd0);
    check("async_rst_busy",  64'(busy),      64'd0);
    check("async_rst_done",  64'(done),      64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 9) == 0);
      seed_load = ($urandom_range(0, 5) == 0);
      r         = {$urandom(), $urandom()};
      seed      = ($urandom_range(0, 3) == 0) ? 33'h0 : r[32:0];
      max_count = 16'($urandom_range(0, 6));
      vec_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    seed_load = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rtg_pattern_gen.md
# rtg_pattern_gen

Hardware random test-pattern generator that sits directly upstream of the c1908 fault-simulation stage. It replaces software `$random` vector creation with a 33-bit maximal-length LFSR. Vectors are presented over a valid/ready handshake, one vector per accepted transfer, until a programmable vector budget is exhausted. Downstream consumers apply each vector to the good and faulty circuits and accept it when they finish evaluating it.

## Interface
Parameters:
- `WIDTH`, 33, vector width; bit 0 drives circuit input g[1], bit 32 drives g[33].
- `SEED`, 33'h1, reset seed and substitute value for an all-zero seed load.
- `CNT_W`, 16, width of the vector budget and the vector index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begins a run; sampled in IDLE and DONE.
- `abort` in 1: ends a run; sampled in RUN.
- `seed_load` in 1: loads `seed` into the LFSR; honoured in IDLE and DONE only.
- `seed` in WIDTH: new seed value.
- `max_count` in CNT_W: number of vectors in a run; latched on the cycle `start` is accepted.
- `vec_valid` out 1: `vec` holds a valid vector.
- `vec_ready` in 1: consumer accepts `vec`.
- `vec` out WIDTH: current vector (LFSR state).
- `vec_index` out CNT_W: zero-based index of the vector on `vec`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- LFSR polynomial x^33 + x^20 + 1, Fibonacci form.
  - Update: `fb = s[32] ^ s[19]`, then `s_next = {s[31:0], fb}`.
  - A transfer is a cycle with `vec_valid && vec_ready`. The LFSR advances only on a transfer.
- A `seed_load` of an all-zero seed loads `SEED` instead, so the LFSR can never lock up at zero.
- States: IDLE, RUN, DONE.
  - IDLE
    - `start` with latched `max_count != 0` goes to RUN.
    - `start` with `max_count == 0` goes straight to DONE; no vector is issued.
  - RUN
    - `vec_valid = 1`.
    - Each transfer increments `vec_index`.
    - A transfer while `vec_index == max_count-1` goes to DONE.
    - `abort` goes to IDLE and takes priority over a simultaneous transfer. The LFSR and index do not update on that cycle.
  - DONE
    - `done = 1` until the next `start`.
    - `start` goes to RUN with `vec_index` cleared.
    - The LFSR continues from its current state, so successive runs never repeat vectors unless the LFSR is reseeded.
- `seed_load` and `start` on the same cycle: the seed is loaded first, and the run starts from the new seed.
- `vec_index` is cleared on `start`. It holds its final value in DONE and IDLE.
- Wrap-around: `max_count` up to 2^CNT_W-1 is supported. The LFSR period (2^33-1) is never reached within one run.

## Timing
- Reset values:
  - state IDLE
  - LFSR = `SEED`
  - `vec_index` = 0
  - `vec_valid`, `busy`, `done` = 0
- `start` accepted at edge N: `vec_valid` = 1 after edge N, carrying the current LFSR state at `vec_index` 0.
- Stability: while `vec_valid && !vec_ready`, `vec` and `vec_index` hold stable.
- Throughput: one vector per cycle when `vec_ready` is held high.
- Last vector: `vec_valid` drops on the edge following the transfer of the last vector, and `done` rises on that same edge.
- All outputs are registered; there is no combinational path from `vec_ready` to `vec`.
- Reset asserted mid-run: immediate return to the reset values. No partial transfer is reported.

## Structure
- Package `rtg_pkg` holds:
  - the state enum `rtg_state_t` (IDLE, RUN, DONE);
  - the tap constants `TAP_HI = 32` and `TAP_LO = 19`;
  - the default `SEED`.
- Sub-module `rtg_lfsr` contains:
  - the WIDTH-bit register;
  - the load path, including zero-seed substitution;
  - the advance-enable path.
- The top level contains the FSM, counter and handshake.

## Test plan
- Reset, `seed_load` 33'h1, `start` with `max_count` 21, `vec_ready` held high.
  - Required sequence: 33'h1, 2, 4, …, 1<<19, then 33'h000100001 at index 20.
  - `done` rises on the next edge.
- Same stimulus with `vec_ready` toggling 1-0-0-1.
  - `vec` and `vec_index` stay unchanged during the stall cycles.
  - The vector sequence is identical to the non-stalled run.
- `seed_load` with `seed` 0.
  - The first vector equals `SEED` (33'h1).
- `abort` asserted at index 5 together with `vec_ready`.
  - Next state is IDLE and `busy` = 0.
  - The LFSR still holds the index-5 vector.
- `start` with `max_count` 0.
  - `done` = 1 on the next cycle and `vec_valid` is never asserted.
- `rst` pulsed while in RUN at index 7.
  - All outputs return to their reset values asynchronously.
  - The LFSR returns to `SEED`.
